// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line fetcher.
// Colour type, transparent key, screen size, fetch FSM states.
package sprite_pkg;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t KEY_COLOR = 12'h808;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int SPR_W_DEF = 21;
  localparam int SPR_H_DEF = 41;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// One sprite row: DEPTH entries of {opaque, rgb444}.
// Ports: clk/rst_n, one write port (i_we/i_waddr/i_wcolor/i_wopq), one comb read port.
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH = 21,
  parameter int unsigned AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  rgb444_t       i_wcolor,
  input  logic          i_wopq,
  input  logic [AW-1:0] i_raddr,
  output rgb444_t       o_rcolor,
  output logic          o_ropq
);

  logic [12:0] r_mem [DEPTH];

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = i_we && (32'(i_waddr) < DEPTH);
  assign w_rd_ok = 32'(i_raddr) < DEPTH;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= {i_wopq, i_wcolor};
    end
  end

  always_comb begin
    o_rcolor = '0;
    o_ropq   = 1'b0;
    if (w_rd_ok) begin
      {o_ropq, o_rcolor} = r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Fetches one sprite row from a palette ROM during hblank, then serves
// registered pixel_on/pixel_color for draw_x. Ports: line request in, ROM side, draw side.
module sprite_line_fetcher #(
  parameter int unsigned SPR_W     = 21,
  parameter int unsigned SPR_H     = 41,
  parameter logic [11:0] KEY_COLOR = sprite_pkg::KEY_COLOR
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        flip,
  output logic [9:0]  rom_addr,
  input  logic [11:0] rom_color,
  input  logic [9:0]  draw_x,
  output logic        pixel_on,
  output logic [11:0] pixel_color,
  output logic        busy,
  output logic        done
);

  import sprite_pkg::*;

  localparam int unsigned CW = $clog2(SPR_W);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [9:0]    r_x_lat;
  logic          r_flip_lat;
  logic [CW-1:0] r_col;
  logic [9:0]    r_base;
  logic          r_line_valid;
  logic          r_pixel_on;
  rgb444_t       r_pixel_color;

  logic [9:0]    w_row;
  logic          w_in_range;
  logic          w_last;
  logic [CW-1:0] w_colm;

  logic [9:0]    w_idx;
  logic          w_hit;
  logic [CW-1:0] w_raddr;
  rgb444_t       w_rcolor;
  logic          w_ropq;
  logic          w_on;

  // Unsigned row; next_y < sprite_y wraps, so test both bounds.
  assign w_row      = next_y - sprite_y;
  assign w_in_range = (next_y >= sprite_y)
                   && (w_row < 10'(SPR_H));
  assign w_last     = (r_col == CW'(SPR_W - 1));

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: line_start restarts from any state
  always_comb begin
    w_next = r_state;
    if (line_start) begin
      w_next = w_in_range ? FETCH : DONE;
    end else begin
      unique case (r_state)
        IDLE:    w_next = IDLE;
        FETCH:   w_next = w_last ? DONE : FETCH;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (r_state == FETCH);
    done     = (r_state == DONE);
    w_colm   = r_flip_lat
             ? CW'(SPR_W - 1) - r_col
             : r_col;
    rom_addr = '0;
    if (busy) begin
      rom_addr = r_base + 10'(w_colm);
    end
  end

  // Request latches and column counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x_lat      <= '0;
      r_flip_lat   <= 1'b0;
      r_col        <= '0;
      r_base       <= '0;
      r_line_valid <= 1'b0;
    end else if (line_start) begin
      r_x_lat      <= sprite_x;
      r_flip_lat   <= flip;
      r_col        <= '0;
      r_base       <= w_row * 10'(SPR_W);
      r_line_valid <= 1'b0;
    end else if (busy) begin
      if (w_last) begin
        r_line_valid <= 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  sprite_line_buffer #(
    .DEPTH (SPR_W),
    .AW    (CW)
  ) u_buf (
    .i_clk    (Clk),
    .i_rst_n  (Reset_n),
    .i_we     (busy),
    .i_waddr  (r_col),
    .i_wcolor (rom_color),
    .i_wopq   (rom_color != KEY_COLOR),
    .i_raddr  (w_raddr),
    .o_rcolor (w_rcolor),
    .o_ropq   (w_ropq)
  );

  // Draw path
  assign w_idx   = draw_x - r_x_lat;
  assign w_hit   = (draw_x >= r_x_lat)
                && (w_idx < 10'(SPR_W));
  assign w_raddr = w_hit ? w_idx[CW-1:0] : '0;
  // Masked while busy so a half-written row never shows
  assign w_on    = r_line_valid & ~busy
                 & w_hit & w_ropq;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pixel_on    <= 1'b0;
      r_pixel_color <= '0;
    end else begin
      r_pixel_on    <= w_on;
      r_pixel_color <= w_on ? w_rcolor : '0;
    end
  end

  assign pixel_on    = r_pixel_on;
  assign pixel_color = r_pixel_color;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench for sprite_line_fetcher.
// Directed plan steps plus random lines against a row/column reference model.
module tb_sprite_line_fetcher;

  localparam int W   = 21;
  localparam int H   = 41;
  localparam int KEY = 'h808;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        line_start;
  logic [9:0]  next_y;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        flip;
  logic [9:0]  rom_addr;
  logic [11:0] rom_color;
  logic [9:0]  draw_x;
  logic        pixel_on;
  logic [11:0] pixel_color;
  logic        busy;
  logic        done;

  logic [11:0] rom [1024];

  int n_pass = 0;
  int n_tot  = 0;

  // reference model of the latched request
  int m_x;
  int m_row;
  bit m_flip;
  bit m_in;
  bit m_valid;

  always #5 Clk = ~Clk;

  assign rom_color = rom[rom_addr];

  sprite_line_fetcher dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .line_start  (line_start),
    .next_y      (next_y),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .flip        (flip),
    .rom_addr    (rom_addr),
    .rom_color   (rom_color),
    .draw_x      (draw_x),
    .pixel_on    (pixel_on),
    .pixel_color (pixel_color),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int maddr(input int c);
    return m_row * W + (m_flip ? W - 1 - c : c);
  endfunction

  task automatic start(input int ny, input int sy,
                       input int sx, input bit fl);
    next_y     = 10'(ny);
    sprite_y   = 10'(sy);
    sprite_x   = 10'(sx);
    flip       = fl;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    m_x     = sx;
    m_flip  = fl;
    m_in    = (ny >= sy) && (ny - sy < H);
    m_row   = ny - sy;
    m_valid = 1'b0;
  endtask

  task automatic run_fetch(input int n);
    for (int c = 0; c < n; c++) begin
      chk("rom_addr", 32'(rom_addr), maddr(c));
      chk("busy_fetch", 32'(busy), 1);
      chk("done_fetch", 32'(done), 0);
      chk("pix_fetch", 32'(pixel_on), 0);
      tick();
    end
  endtask

  task automatic finish_line();
    if (m_in) begin
      run_fetch(W);
      m_valid = 1'b1;
    end else begin
      chk("busy_oor", 32'(busy), 0);
    end
    chk("done_pulse", 32'(done), 1);
    chk("busy_done", 32'(busy), 0);
    tick();
    chk("done_clear", 32'(done), 0);
  endtask

  task automatic sweep();
    int c;
    int col;
    bit on;
    for (int dx = m_x - 2; dx <= m_x + W + 2; dx++) begin
      draw_x = 10'(dx);
      tick();
      c   = dx - m_x;
      on  = 1'b0;
      col = 0;
      if (m_valid && c >= 0 && c < W) begin
        col = int'(rom[maddr(c)]);
        on  = (col != KEY);
      end
      chk("pixel_on", 32'(pixel_on), 32'(on));
      chk("pixel_color", 32'(pixel_color),
          on ? col : 0);
    end
  endtask

  initial begin
    int sy;
    int ny;
    int sx;
    for (int i = 0; i < 1024; i++) begin
      rom[i] = ($urandom_range(0, 4) == 0)
             ? 12'h808
             : 12'($urandom_range(0, 4095));
    end
    rom[125] = 12'hF30;
    rom[108] = 12'h808;
    rom[105] = 12'h0A5;

    Reset_n    = 1'b0;
    line_start = 1'b0;
    next_y     = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    flip       = 1'b0;
    draw_x     = '0;
    m_valid    = 1'b0;
    m_x        = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pix", 32'(pixel_on), 0);
    chk("rst_color", 32'(pixel_color), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    #4 Reset_n = 1'b1;
    tick();

    // normal row, col 3 transparent
    start(105, 100, 200, 1'b0);
    finish_line();
    sprite_x = 10'd50;
    sweep();

    // mirrored row: addr 125 shows at sprite_x
    start(105, 100, 200, 1'b1);
    finish_line();
    draw_x = 10'd200;
    tick();
    chk("mirror_on", 32'(pixel_on), 1);
    chk("mirror_col", 32'(pixel_color), 'hF30);
    sweep();

    // out of range above and below
    start(99, 100, 200, 1'b0);
    finish_line();
    sweep();
    start(141, 100, 200, 1'b0);
    finish_line();
    sweep();

    // right-edge clipping
    start(130, 100, 630, 1'b0);
    finish_line();
    sweep();

    // restart at cycle 10 of fetch
    start(105, 100, 300, 1'b0);
    run_fetch(10);
    next_y     = 10'd106;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    m_row      = 6;
    chk("restart_addr", 32'(rom_addr), 126);
    finish_line();
    chk("restart_done1", 32'(done), 0);
    sweep();

    // reset mid-fetch
    start(110, 100, 250, 1'b0);
    run_fetch(5);
    Reset_n = 1'b0;
    #2;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pix", 32'(pixel_on), 0);
    chk("arst_addr", 32'(rom_addr), 0);
    #2 Reset_n = 1'b1;
    m_valid = 1'b0;
    tick();
    chk("post_rst_done", 32'(done), 0);
    sweep();

    // random lines
    for (int k = 0; k < 12; k++) begin
      sy = $urandom_range(0, 400);
      sx = $urandom_range(2, 630);
      case ($urandom_range(0, 3))
        0:       ny = sy + H + $urandom_range(0, 20);
        1:       ny = (sy > 0) ? sy - 1 : sy + H;
        default: ny = sy + $urandom_range(0, H - 1);
      endcase
      start(ny, sy, sx, 1'($urandom_range(0, 1)));
      sprite_x = 10'($urandom_range(0, 639));
      finish_line();
      sweep();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
Reader side of a combinational sprite palette ROM (10-bit read_address in, 12-bit RGB444 output_color out). On each line_start pulse, the block fetches one sprite row into an internal line buffer, one ROM word per cycle, during horizontal blanking. During the active line it returns the registered colour and an opaque flag for the current draw_x. It sits between the VGA timing/colour mapper and one sprite ROM instance. Its mirror option lets a right-facing sprite ROM also render left-facing frames.

Parameters:
SPR_W, 21, sprite width in pixels
SPR_H, 41, sprite height in pixels; SPR_W*SPR_H must be at most 1024
KEY_COLOR, 12'h808, transparent colour; pixels of this colour are never drawn

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
line_start  in  1  single-cycle pulse at hblank start; requests fetch of line next_y
next_y  in  10  screen line about to be displayed
sprite_x  in  10  sprite left edge, screen coordinates
sprite_y  in  10  sprite top edge, screen coordinates
flip  in  1  1 = mirror horizontally
rom_addr  out  10  ROM read address (combinational from state)
rom_color  in  12  ROM data, valid in the same cycle as rom_addr
draw_x  in  10  current pixel column
pixel_on  out  1  registered: sprite opaque at draw_x
pixel_color  out  12  registered colour, valid when pixel_on=1
busy  out  1  high while in FETCH
done  out  1  one-cycle pulse when a line request completes

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: every register is cleared while Reset_n=0. State=IDLE, pixel_on=0, pixel_color=0, busy=0, done=0, rom_addr=0, line_valid=0, all opaque bits=0.
- States: IDLE, FETCH, DONE.
- IDLE, on line_start:
  - Latch sprite_x as x_lat and flip as flip_lat.
  - Compute row = next_y - sprite_y (10-bit unsigned). The line is in range iff next_y >= sprite_y and row < SPR_H.
  - In range: col <= 0, base <= row*SPR_W, go to FETCH.
  - Out of range: line_valid <= 0, go to DONE.
- FETCH:
  - rom_addr = base + (flip_lat ? SPR_W-1-col : col).
  - Each cycle: buf[col] <= rom_color; opq[col] <= (rom_color != KEY_COLOR); col increments.
  - After col = SPR_W-1 is written: line_valid <= 1, go to DONE.
  - Fetch takes exactly SPR_W cycles.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 exactly while in FETCH.
- line_start arriving in FETCH or DONE restarts the request with the new inputs: latches and row are recomputed, line_valid <= 0, col <= 0. The aborted request never produces done.
- Draw path (1-cycle latency):
  - idx = draw_x - x_lat (10-bit).
  - pixel_on <= line_valid & !busy & (draw_x >= x_lat) & (idx < SPR_W) & opq[idx].
  - pixel_color <= buf[idx] when pixel_on is next 1, else 12'h000.
  - pixel_on is forced 0 during FETCH so no torn line is shown.
- Edge clipping: sprite_x + SPR_W may exceed 639. Columns past the screen edge are simply never requested; nothing wraps.
- Sprite moves: a change to sprite_x mid-line has no effect until the next line_start.
- Row address arithmetic: base is computed at 10 bits. The maximum address is SPR_W*SPR_H-1 = 860 with defaults.
- Reset mid-FETCH: the line buffer contents become don't-care but are masked, since line_valid=0. No done pulse is produced.

Decomposition:
- Package sprite_pkg:
  - Colour typedef rgb444_t (logic [11:0]).
  - Constant KEY_COLOR = 12'h808.
  - Screen constants H_ACTIVE=640, V_ACTIVE=480.
  - Enum fetch_state_t {IDLE, FETCH, DONE}.
- One natural sub-module, sprite_line_buffer: SPR_W x 13-bit register file (12-bit colour plus opaque bit), with one write port and one combinational read port.
- The FSM and address generation stay in the top module.

Test Plan:
- Normal row: sprite_y=100, next_y=105, flip=0, line_start -> rom_addr steps 105..125 over 21 cycles; busy high for 21 cycles; done pulse on cycle 22.
- Mirrored row: same stimulus with flip=1 -> rom_addr steps 125 down to 105. A ROM word of 12'hF30 at addr 125 appears at draw_x=sprite_x, one cycle after draw_x is applied.
- Transparency and clipping: ROM returns 12'h808 at col 3 -> pixel_on=0 at draw_x=sprite_x+3. Also draw_x = sprite_x-1 -> pixel_on=0 and draw_x = sprite_x+21 -> pixel_on=0.
- Out of range: next_y=99 or next_y=141 with sprite_y=100 -> no FETCH, done pulses on the cycle after line_start, pixel_on stays 0 across the line.
- Restart: second line_start at cycle 10 of FETCH with next_y=106 -> col restarts, rom_addr begins at 126, exactly one done pulse, 21 cycles after the second pulse.
- Reset mid-fetch: Reset_n low at cycle 5 of FETCH -> busy, done and pixel_on go 0 immediately (asynchronously). After release, draw_x sweep with no new line_start gives pixel_on=0.
